// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the forwarding/hazard controller.
//   SEL_*   : ALU operand mux select codes (2'b11 is never driven)
//   stage_t : shadow-pipeline entry {valid, we, load, rd}
//   state_t : load-use FSM states
package pipe_pkg;

  localparam int unsigned RD_W = 3;
  localparam int unsigned NUM_OPS = 2;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic            load;
    logic [RD_W-1:0] rd;
  } stage_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_cmp.sv
// fwd_cmp: single-operand priority comparator.
//   use_src : instruction in ID reads this operand
//   src     : source register address
//   ex, mem : shadow entries for the EX and MEM stages
//   sel     : forwarding select (EX beats MEM; r0 never forwarded)
//   ld_hit  : operand depends on a load still in EX (load-use hazard)
module fwd_cmp
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W = RD_W
) (
  input  logic            use_src,
  input  logic [RA_W-1:0] src,
  input  stage_t          ex,
  input  stage_t          mem,
  output logic [1:0]      sel,
  output logic            ld_hit
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;

  // r0 reads are constant zero, so they never need a forwarded value.
  assign src_live = use_src && (src != '0);
  assign ex_hit   = src_live && ex.valid  && ex.we  && (ex.rd  == src);
  assign mem_hit  = src_live && mem.valid && mem.we && (mem.rd == src);
  assign ld_hit   = ex_hit && ex.load;

  always_comb begin
    sel = SEL_RF;
    if (ex_hit)       sel = SEL_EXMEM;
    else if (mem_hit) sel = SEL_MEMWB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and load-use hazard control for the 5-stage
// 16-bit MIPS pipeline.
//   clk, rst          : clock, async active-high reset
//   id_*              : decoded fields of the instruction currently in ID
//   hold              : freeze everything (memory busy)
//   flush             : squash the ID instruction (taken branch)
//   fwd_a_sel/b_sel   : registered operand mux selects, valid in EX cycle
//   stall             : combinational; freeze PC + IF/ID, bubble into EX
//   stall_cnt         : saturating count of load-use stalls taken
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d;
  state_t state_q, state_d;

  logic [NUM_OPS-1:0][RA_W-1:0] src;
  logic [NUM_OPS-1:0]           use_src;
  logic [NUM_OPS-1:0][1:0]      sel_c;
  logic [NUM_OPS-1:0]           ld_hit;

  logic hazard;
  logic take;
  logic issue;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_cmp #(.RA_W(RA_W)) u_cmp (
      .use_src (use_src[g]),
      .src     (src[g]),
      .ex      (ex_q),
      .mem     (mem_q),
      .sel     (sel_c[g]),
      .ld_hit  (ld_hit[g])
    );
  end

  assign hazard = id_valid && (|ld_hit);

  // stall is visible even while held so the front end keeps its freeze;
  // only the edge-side effects (bubble, count, state) wait for !hold.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    take    = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard && !flush) stall = 1'b1;
        if (stall && !hold) begin
          take    = 1'b1;
          state_d = BUBBLE;
        end
      end
      BUBBLE: begin
        if (!hold) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A stalled or squashed instruction enters EX as a bubble.
  assign issue = id_valid && !flush && !take;

  always_comb begin
    ex_d       = '0;
    ex_d.valid = issue;
    ex_d.we    = issue && id_we;
    ex_d.load  = issue && id_load;
    ex_d.rd    = issue ? id_rd : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
      stall_cnt <= '0;
    end else if (!hold) begin
      state_q   <= state_d;
      wb_q      <= mem_q;
      mem_q     <= ex_q;
      ex_q      <= ex_d;
      fwd_a_sel <= issue ? sel_c[0] : SEL_RF;
      fwd_b_sel <= issue ? sel_c[1] : SEL_RF;
      if (take && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // The register file writes in the first half cycle, so a WB producer is
  // already served by the register-file path; the entry is kept for
  // visibility only.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage 16-bit MIPS pipeline.
- Tracks the destination registers of the instructions in EX, MEM and WB.
- Produces registered 2-bit select codes for the two ALU-operand 3:1 muxes: register file / EX-MEM forward / MEM-WB forward.
- Detects load-use hazards and drives a one-cycle stall/bubble. Also honours an external pipeline hold and a branch flush.

Parameters:
- RA_W, 3, register-address width (8 architectural registers; r0 hardwired zero)
- CNT_W, 16, width of the saturating stall-event counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  RA_W  source A register
- id_rt  in  RA_W  source B register
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_rd  in  RA_W  destination register
- id_we  in  1  instruction writes rd
- id_load  in  1  instruction is a load
- hold  in  1  external freeze (memory busy); all pipeline state holds
- flush  in  1  branch taken; ID instruction is squashed
- fwd_a_sel  out  2  operand-A mux select for the instruction now in EX
- fwd_b_sel  out  2  operand-B mux select for the instruction now in EX
- stall  out  1  freeze PC and IF/ID; EX receives a bubble
- stall_cnt  out  CNT_W  count of load-use stalls, saturating

Behaviour:
- Select encoding (fixed by the mux): 2'b00 = register file, 2'b01 = EX/MEM result, 2'b10 = MEM/WB result. 2'b11 is never driven.
- Internal shadow pipeline: three entries {valid, we, load, rd} for EX, MEM and WB. It advances every cycle that hold=0; on hold=1 everything holds, outputs included.
- Reset (async, rst=1): all shadow entries invalid, fwd_a_sel=fwd_b_sel=2'b00, stall=0, stall_cnt=0, FSM in RUN.
- Select computation (combinational on the ID inputs, registered into fwd_*_sel on the advancing edge, so selects are valid during the instruction's EX cycle).
  - Operand A, highest priority first:
    - 01 if id_use_rs, EX entry valid&we, EX.rd==id_rs, id_rs!=0
    - else 10 if the same test passes against the MEM entry
    - else 00
  - Operand B: identical, using id_rt / id_use_rt.
  - Younger producer (EX) always wins over MEM.
- Load-use hazard: id_valid & EX entry valid&we&load & EX.rd!=0 & ((id_use_rs & EX.rd==id_rs) | (id_use_rt & EX.rd==id_rt)).
- FSM, states RUN and BUBBLE:
  - RUN, hazard & !hold & !flush: stall=1 combinationally this cycle. On the edge, insert an invalid entry into EX, force selects to 00, go to BUBBLE, increment stall_cnt (saturates at all-ones).
  - BUBBLE: stall=0. The load is now in MEM, so the dependent re-evaluates and receives select 10. Return to RUN on the next advancing edge. A second hazard cannot occur in BUBBLE because the EX entry is invalid.
  - hold=1 in either state: state frozen; stall output still reflects the hazard; no count increment.
- flush=1 (not held): the EX entry loaded on the edge is invalid, selects 00, stall=0. flush overrides a hazard in the same cycle and no count is taken.
- id_valid=0: EX entry invalid and selects 00.
- r0 as destination never forwards and never triggers a stall.
- Latency: selects registered, 1 cycle after ID inputs; stall combinational, 0 cycles.
- Reset asserted mid-stall: returns to RUN immediately; the bubble is discarded.

Decomposition:
- Shared package pipe_pkg:
  - select constants SEL_RF=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10
  - stage-entry struct/typedef {valid, we, load, rd}
  - FSM state enum {RUN, BUBBLE}
- One natural sub-module: fwd_cmp, a single-operand priority comparator. Instantiate it twice, for A and B.

Test Plan:
- ALU chain: add r1 then sub r2,r1,r3 back-to-back -> during sub's EX cycle fwd_a_sel=01, fwd_b_sel=00, stall never 1.
- Gap of one: add r1; nop; or r4,r3,r1 -> fwd_b_sel=10 in or's EX cycle.
- Load-use: lw r2 then add r5,r2,r2 -> stall=1 for exactly one cycle. Next cycle both selects 10, stall_cnt 0->1.
- Double producer: add r1; add r1; sub r6,r1,r0 -> fwd_a_sel=01 (EX wins), fwd_b_sel=00 (r0 never forwarded).
- hold=1 for 3 cycles during a load-use stall -> stall stays 1, selects and state unchanged, stall_cnt increments once total. flush together with hazard -> stall=0, count unchanged.
- Saturation and reset: preload the counter to 16'hFFFE, create 3 load-use hazards -> stall_cnt ends 16'hFFFF. Pulse rst mid-stall -> all outputs 0 asynchronously.
